// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and sizing for the multiply/divide unit
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(MULDIV_WIDTH);

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between the datapath and the multiply/divide unit
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             HiWrite;
    logic             LoWrite;
    logic [WIDTH-1:0] WriteData;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteData,
        input  Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteData,
        output Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/muldiv_sign_adj.sv
// rtl/muldiv_sign_adj.sv - operand magnitude conversion and signed result fix-up
module muldiv_sign_adj #(
    parameter int WIDTH = 32
) (
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a_raw,
    input  logic [WIDTH-1:0] b_raw,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             neg_a,
    output logic             neg_b,
    input  logic             is_div,
    input  logic             dbz,
    input  logic             neg_res,
    input  logic             neg_rem,
    input  logic [WIDTH-1:0] res_hi,
    input  logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    assign neg_a    = signed_op & a_raw[WIDTH-1];
    assign neg_b    = signed_op & b_raw[WIDTH-1];
    assign a_mag    = neg_a ? -a_raw : a_raw;
    assign b_mag    = neg_b ? -b_raw : b_raw;
    assign prod     = {res_hi, res_lo};
    assign prod_neg = -prod;

    always_comb begin
        fix_hi = res_hi;
        fix_lo = res_lo;
        if (is_div) begin
            // On a zero divisor the remainder holds |dividend|; restoring its sign yields the raw dividend.
            fix_hi = neg_rem ? -res_hi : res_hi;
            fix_lo = dbz ? '1 : (neg_res ? -res_lo : res_lo);
        end else if (neg_res) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
// Signed MULT/DIV are built in only when MULDIV_SIGNED_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input logic     clock,
    input logic     Reset,
    muldiv_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shr_q, shr_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             is_div;
    logic             dbz_now;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH-1:0] acc_step, shr_step;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign is_div  = (op_q == OP_DIVU) || (op_q == OP_DIV);
    assign dbz_now = is_div && (opb_q == '0);

`ifdef MULDIV_SIGNED_EN
    logic neg_a, neg_b;
    logic neg_res_q, neg_res_d;
    logic neg_rem_q, neg_rem_d;

    muldiv_sign_adj #(.WIDTH(WIDTH)) u_sign_adj (
        .signed_op (bus.Op[0]),
        .a_raw     (bus.OperandA),
        .b_raw     (bus.OperandB),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .neg_a     (neg_a),
        .neg_b     (neg_b),
        .is_div    (is_div),
        .dbz       (dbz_now),
        .neg_res   (neg_res_q),
        .neg_rem   (neg_rem_q),
        .res_hi    (acc_step),
        .res_lo    (shr_step),
        .fix_hi    (fix_hi),
        .fix_lo    (fix_lo)
    );
`else
    assign a_mag  = bus.OperandA;
    assign b_mag  = bus.OperandB;
    assign fix_hi = acc_step;
    assign fix_lo = shr_step;
`endif

    // acc is the product high half / partial remainder; shr holds multiplier bits or dividend/quotient bits.
    always_comb begin
        add_sum  = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opb_q} : '0);
        shifted  = {acc_q, shr_q[WIDTH-1]};
        sub_diff = shifted - {1'b0, opb_q};
        if (is_div) begin
            if (!sub_diff[WIDTH]) begin
                acc_step = sub_diff[WIDTH-1:0];
                shr_step = {shr_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = shifted[WIDTH-1:0];
                shr_step = {shr_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = add_sum[WIDTH:1];
            shr_step = {add_sum[0], shr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        shr_d   = shr_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (bus.Start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    op_d    = op_e'(bus.Op);
                    cnt_d   = '0;
                    acc_d   = '0;
                    shr_d   = a_mag;
                    opb_d   = b_mag;
`ifdef MULDIV_SIGNED_EN
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
`endif
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (bus.HiWrite) hi_d = bus.WriteData;
                    if (bus.LoWrite) lo_d = bus.WriteData;
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                shr_d = shr_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dbz_d   = dbz_now;
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULTU;
            cnt_q   <= '0;
            acc_q   <= '0;
            shr_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shr_q   <= shr_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;
    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, downstream of the register file in the MIPS datapath. It consumes the two register-file read operands (ReadData1 -> OperandA, ReadData2 -> OperandB) and computes one radix-2 step per cycle. Results are held in Hi/Lo for later mfhi/mflo reads. It also services mthi/mtlo writes.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-low reset; clears all state.
Start  input  1  request to begin the operation given by Op; sampled at the rising edge.
Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
OperandA  input  WIDTH  multiplicand / dividend.
OperandB  input  WIDTH  multiplier / divisor.
HiWrite  input  1  mthi: load WriteData into Hi.
LoWrite  input  1  mtlo: load WriteData into Lo.
WriteData  input  WIDTH  data for mthi/mtlo.
Busy  output  1  operation in progress.
Done  output  1  one-cycle pulse; Hi/Lo hold the new result.
DivByZero  output  1  valid with Done; divisor was zero.
Hi  output  WIDTH  product high half / remainder.
Lo  output  WIDTH  product low half / quotient.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; Hi=Lo=0; Busy=Done=DivByZero=0; iteration counter=0.
- States:
  - IDLE: Busy=0, Done=0.
  - RUN: Busy=1.
  - FINISH: Busy=0, Done=1.
- Start acceptance:
  - Start=1 in IDLE or FINISH: latch operands and Op, set counter=0, go to RUN.
  - Start while in RUN: ignored.
- RUN performs exactly WIDTH iterations, one per cycle.
  - On the edge completing iteration WIDTH: write Hi/Lo and go to FINISH.
  - FINISH lasts one cycle, then goes to IDLE unless a new Start is accepted.
- Latency: Start sampled at edge k -> Busy=1 for cycles after edges k..k+WIDTH-1 -> Done=1 with the new Hi/Lo in the cycle after edge k+WIDTH. For WIDTH=32, that is 33 cycles from the Start edge to Done.
- Multiply: shift-add, 2*WIDTH-bit product. Hi = bits[2W-1:W], Lo = bits[W-1:0].
- Divide: restoring shift-subtract. Lo = quotient, Hi = remainder.
- Divide by zero (OperandB=0 on DIV/DIVU): run the full WIDTH cycles anyway. Result is Lo=all ones, Hi=dividend, DivByZero=1 during the Done cycle. DivByZero=0 otherwise.
- Hi/Lo do not change during RUN; they only change at completion or on mthi/mtlo.
- HiWrite/LoWrite:
  - Honoured only in IDLE or FINISH; the write takes effect at the next edge.
  - Ignored during RUN.
  - If Start and HiWrite/LoWrite are both asserted, Start wins and the write is dropped.
  - HiWrite and LoWrite together write both registers.
- Reset asserted mid-operation aborts immediately. No Done pulse follows.

Optional Feature:
Macro MULDIV_SIGNED_EN.
- Defined: Op[0]=1 selects signed operation.
  - Operands are converted to magnitudes before iterating and the result is fixed up at completion.
  - Product sign = sign(A) xor sign(B).
  - Quotient sign = sign(A) xor sign(B); remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
  - Signed divide by zero gives the same result as the unsigned case, on raw operands.
- Undefined: Op[0] is ignored; MULT behaves as MULTU and DIV as DIVU. No fix-up logic is present.
- Latency is identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - Op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV).
  - State encoding (ST_IDLE, ST_RUN, ST_FINISH).
  - The iteration-counter width, $clog2(WIDTH)+1.
- One sub-module is natural: muldiv_sign_adj, a combinational magnitude/negate and result fix-up block. It is instantiated only under MULDIV_SIGNED_EN.
- The state machine and datapath stay in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, Done exactly 33 cycles after the Start edge, Busy high for 32 cycles.
- DIVU 100 / 7 -> Lo=14, Hi=2, DivByZero=0; then DIVU 5 / 0 -> Lo=0xFFFFFFFF, Hi=5, DivByZero=1 during the Done cycle only.
- Start pulsed again during RUN with different operands -> ignored; first result unchanged. Back-to-back Start in the FINISH cycle -> accepted, second Done 33 cycles later.
- mtlo 0x12345678 in IDLE -> Lo=0x12345678 next cycle. Same write during RUN -> no effect. Start together with HiWrite -> Hi keeps the old value until the result is written.
- Reset dropped to 0 at iteration 10 -> Busy=0, Hi=Lo=0 immediately, no Done. After release, a new MULTU 3x4 -> Lo=12, Hi=0.
- (MULDIV_SIGNED_EN) MULT -3 x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 0x80000000 / -1 -> Lo=0x80000000, Hi=0. Without the macro, MULT -3 x 7 -> Hi=0x00000006, Lo=0xFFFFFFEB.
